// File: rtl/ahb_arb_pkg.sv
// Shared types and index helpers for the AHB arbiter and the bus master mux.
package ahb_arb_pkg;

    localparam int MASTER_IDX_W = 4;

    typedef logic [MASTER_IDX_W-1:0] master_idx_t;

    // Grants are one-hot, so OR-ing the indices of the set bits yields the owner.
    function automatic master_idx_t onehot_to_idx(input logic [15:0] oh);
        master_idx_t idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | master_idx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [15:0] idx_to_onehot(input master_idx_t idx);
        logic [15:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbitration handshake between the masters and the arbiter.
interface ahb_arbiter_if
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    master_idx_t            HMASTER;
    logic                   HMASTLOCK;

    // Requester side: drives requests and ready, observes the grant.
    modport master (
        output HBUSREQ, HLOCK, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    // Arbiter side.
    modport slave (
        input  HBUSREQ, HLOCK, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter_rr_picker.sv
// Round-robin winner selection: first requester above the last owner, wrapping.
module rr_picker
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  master_idx_t            last,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   valid
);

    // Pass one scans above the last owner, pass two wraps to the bottom and
    // ends on the last owner itself, so it is picked only when alone.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!valid && req[j] && (j > int'(last))) begin
                grant[j] = 1'b1;
                valid    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!valid && req[j] && (j <= int'(last))) begin
                grant[j] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with locked transfers, bus parking and a hold limit.
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
) (
    input logic         HCLK,
    input logic         HRESET,
    ahb_arbiter_if.slave bus
);

    if (DEFAULT_MASTER >= NUM_MASTERS || NUM_MASTERS < 2 || NUM_MASTERS > 16
        || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
        $error("ahb_arbiter: parameter out of range");
    end

    localparam master_idx_t DEFAULT_IDX = master_idx_t'(DEFAULT_MASTER);
    localparam logic [7:0]  HOLD_MAX    = 8'(MAX_HOLD);
    localparam logic [NUM_MASTERS-1:0] DEFAULT_OH =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [7:0]             hold_cnt;
    logic [7:0]             hold_nxt;
    master_idx_t            hmaster_q;
    logic                   hmastlock_q;

    logic [15:0]            grant_ext;
    master_idx_t            owner;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   other_req;
    logic                   hold_full;
    logic                   arb_en;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic                   pick_valid;

    assign grant_ext  = 16'(grant_q);
    assign owner      = onehot_to_idx(grant_ext);
    assign owner_req  = |(bus.HBUSREQ & grant_q);
    assign owner_lock = |(bus.HLOCK & grant_q);
    assign other_req  = |(bus.HBUSREQ & ~grant_q);
    assign hold_full  = (hold_cnt == HOLD_MAX);

    // A locked owner is never moved; otherwise move when the owner lets go
    // or has used up its tenure while someone else waits.
    assign arb_en = bus.HREADY && !owner_lock &&
                    (!owner_req || (hold_full && other_req));

    rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .req   (bus.HBUSREQ),
        .last  (owner),
        .grant (pick_oh),
        .valid (pick_valid)
    );

    // Next grant and tenure counter.
    always_comb begin
        grant_nxt = grant_q;
        hold_nxt  = hold_cnt;
        if (arb_en) begin
            grant_nxt = pick_valid ? pick_oh : DEFAULT_OH;
        end
        if (grant_nxt != grant_q) begin
            hold_nxt = '0;
        end else if (bus.HREADY && other_req && !owner_lock && !hold_full) begin
            hold_nxt = hold_cnt + 8'd1;
        end
    end

    // Grant, counter and address-phase ownership registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q     <= DEFAULT_OH;
            hold_cnt    <= '0;
            hmaster_q   <= DEFAULT_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            grant_q  <= grant_nxt;
            hold_cnt <= hold_nxt;
            if (bus.HREADY) begin
                hmaster_q   <= owner;
                hmastlock_q <= owner_lock && owner_req;
            end
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed table, corner sequences and
// randomized traffic against a rule-level reference model.
module tb_ahb_arbiter;

    localparam int N     = 2;
    localparam int DEF   = 0;
    localparam int HOLDM = 4;

    logic HCLK = 1'b0;
    logic HRESET;

    ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_arbiter #(
        .NUM_MASTERS   (N),
        .DEFAULT_MASTER(DEF),
        .MAX_HOLD      (HOLDM)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: owner index, tenure count, address-phase owner.
    int m_owner;
    int m_hold;
    int m_hm;
    bit m_hml;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input logic [1:0] req, input logic [1:0] lock,
                                       input logic rdy, input logic rst);
        bit oreq, olock, others;
        int nxt, nhold;
        if (rst) begin
            m_owner = DEF; m_hold = 0; m_hm = DEF; m_hml = 0;
            return;
        end
        oreq   = req[m_owner];
        olock  = lock[m_owner];
        others = 0;
        for (int k = 0; k < N; k++) if (k != m_owner && req[k]) others = 1;
        nxt = m_owner;
        if (rdy && !olock && (!oreq || (m_hold == HOLDM && others))) begin
            nxt = DEF;
            for (int k = 1; k <= N; k++) begin
                if (req[(m_owner + k) % N]) begin
                    nxt = (m_owner + k) % N;
                    break;
                end
            end
        end
        if (nxt != m_owner) nhold = 0;
        else if (rdy && others && !olock) nhold = (m_hold + 1 > HOLDM) ? HOLDM : m_hold + 1;
        else nhold = m_hold;
        if (rdy) begin
            m_hm  = m_owner;
            m_hml = olock && oreq;
        end
        m_owner = nxt;
        m_hold  = nhold;
    endfunction

    // Drive one cycle, advance the model on the edge, compare just after it.
    task automatic step(input logic [1:0] req, input logic [1:0] lock,
                        input logic rdy, input logic rst);
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HREADY  = rdy;
        HRESET      = rst;
        @(posedge HCLK);
        model_step(req, lock, rdy, rst);
        #1;
        check("model_grant",     32'(bus.HGRANT),    32'(1 << m_owner));
        check("model_hmaster",   32'(bus.HMASTER),   32'(m_hm));
        check("model_hmastlock", 32'(bus.HMASTLOCK), 32'(m_hml));
        check("model_hold",      32'(dut.hold_cnt),  32'(m_hold));
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] lock;
        logic       rdy;
        logic [1:0] grant;
        logic [3:0] hm;
        logic       hml;
        logic [7:0] hold;
    } vec_t;

    vec_t vecs[23];

    initial begin
        logic [1:0] gseen[$];
        int runs[$];
        int run_len;
        logic [1:0] r_req, r_lock;
        logic r_rdy, r_rst;

        bus.HBUSREQ = '0;
        bus.HLOCK   = '0;
        bus.HREADY  = 1'b1;
        HRESET      = 1'b1;

        //            req    lock   rdy   grant  hm    hml   hold
        vecs[0]  = '{2'b00, 2'b00, 1'b1, 2'b01, 4'd0, 1'b0, 8'd0}; // parked
        vecs[1]  = '{2'b10, 2'b00, 1'b1, 2'b10, 4'd0, 1'b0, 8'd0}; // handover
        vecs[2]  = '{2'b10, 2'b00, 1'b1, 2'b10, 4'd1, 1'b0, 8'd0};
        vecs[3]  = '{2'b00, 2'b00, 1'b1, 2'b01, 4'd1, 1'b0, 8'd0}; // back to park
        vecs[4]  = '{2'b00, 2'b00, 1'b1, 2'b01, 4'd0, 1'b0, 8'd0};
        vecs[5]  = '{2'b10, 2'b00, 1'b0, 2'b01, 4'd0, 1'b0, 8'd0}; // wait states
        vecs[6]  = '{2'b10, 2'b00, 1'b0, 2'b01, 4'd0, 1'b0, 8'd0};
        vecs[7]  = '{2'b10, 2'b00, 1'b0, 2'b01, 4'd0, 1'b0, 8'd0};
        vecs[8]  = '{2'b10, 2'b00, 1'b1, 2'b10, 4'd0, 1'b0, 8'd0};
        vecs[9]  = '{2'b10, 2'b00, 1'b1, 2'b10, 4'd1, 1'b0, 8'd0};
        vecs[10] = '{2'b11, 2'b00, 1'b1, 2'b10, 4'd1, 1'b0, 8'd1}; // contention
        vecs[11] = '{2'b11, 2'b00, 1'b1, 2'b10, 4'd1, 1'b0, 8'd2};
        vecs[12] = '{2'b11, 2'b00, 1'b0, 2'b10, 4'd1, 1'b0, 8'd2};
        vecs[13] = '{2'b11, 2'b00, 1'b1, 2'b10, 4'd1, 1'b0, 8'd3};
        vecs[14] = '{2'b11, 2'b00, 1'b1, 2'b10, 4'd1, 1'b0, 8'd4};
        vecs[15] = '{2'b11, 2'b00, 1'b1, 2'b01, 4'd1, 1'b0, 8'd0}; // hold limit
        vecs[16] = '{2'b01, 2'b00, 1'b1, 2'b01, 4'd0, 1'b0, 8'd0};
        vecs[17] = '{2'b11, 2'b01, 1'b1, 2'b01, 4'd0, 1'b1, 8'd0}; // locked
        vecs[18] = '{2'b11, 2'b01, 1'b1, 2'b01, 4'd0, 1'b1, 8'd0};
        vecs[19] = '{2'b10, 2'b00, 1'b1, 2'b10, 4'd0, 1'b0, 8'd0};
        vecs[20] = '{2'b10, 2'b10, 1'b1, 2'b10, 4'd1, 1'b1, 8'd0};
        vecs[21] = '{2'b00, 2'b10, 1'b1, 2'b10, 4'd1, 1'b0, 8'd0}; // lock w/o req
        vecs[22] = '{2'b00, 2'b00, 1'b1, 2'b01, 4'd1, 1'b0, 8'd0};

        // Reset for two cycles with no requests.
        step(2'b00, 2'b00, 1'b1, 1'b1);
        step(2'b00, 2'b00, 1'b1, 1'b1);
        check("reset_grant",     32'(bus.HGRANT),    32'h1);
        check("reset_hmaster",   32'(bus.HMASTER),   32'h0);
        check("reset_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
        check("reset_hold",      32'(dut.hold_cnt),  32'h0);

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].req, vecs[i].lock, vecs[i].rdy, 1'b0);
            check($sformatf("vec%0d_grant", i),     32'(bus.HGRANT),    32'(vecs[i].grant));
            check($sformatf("vec%0d_hmaster", i),   32'(bus.HMASTER),   32'(vecs[i].hm));
            check($sformatf("vec%0d_hmastlock", i), 32'(bus.HMASTLOCK), 32'(vecs[i].hml));
            check($sformatf("vec%0d_hold", i),      32'(dut.hold_cnt),  32'(vecs[i].hold));
        end

        // Fairness: continuous contention gives alternating 5-cycle tenures.
        gseen.push_back(bus.HGRANT);
        for (int i = 0; i < 30; i++) begin
            step(2'b11, 2'b00, 1'b1, 1'b0);
            gseen.push_back(bus.HGRANT);
        end
        run_len = 1;
        for (int i = 1; i < gseen.size(); i++) begin
            if (gseen[i] == gseen[i-1]) run_len++;
            else begin
                runs.push_back(run_len);
                run_len = 1;
            end
        end
        check("fair_run_count_ge5", 32'(runs.size() >= 5), 32'h1);
        for (int i = 0; i < runs.size() && i < 5; i++) begin
            check($sformatf("fair_tenure%0d", i), 32'(runs[i]), 32'd5);
        end

        // Locked sequence: master 0 keeps the bus for 20 cycles despite master 1.
        step(2'b00, 2'b00, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(2'b11, 2'b01, 1'b1, 1'b0);
            check($sformatf("lock_grant%0d", i), 32'(bus.HGRANT), 32'h1);
        end
        check("lock_hmastlock", 32'(bus.HMASTLOCK), 32'h1);
        step(2'b10, 2'b00, 1'b1, 1'b0);
        check("unlock_grant", 32'(bus.HGRANT), 32'h2);

        // Reset while master 1 is locked and owning.
        for (int i = 0; i < 3; i++) step(2'b10, 2'b10, 1'b1, 1'b0);
        check("prelock_hmastlock", 32'(bus.HMASTLOCK), 32'h1);
        step(2'b10, 2'b10, 1'b1, 1'b1);
        check("rstlock_grant",     32'(bus.HGRANT),    32'h1);
        check("rstlock_hmaster",   32'(bus.HMASTER),   32'h0);
        check("rstlock_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
        check("rstlock_hold",      32'(dut.hold_cnt),  32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r_req  = 2'($urandom_range(0, 3));
            r_lock = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            r_rdy  = ($urandom_range(0, 3) != 0);
            r_rst  = ($urandom_range(0, 63) == 0);
            step(r_req, r_lock, r_rdy, r_rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
